// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote, configurable
// frame format, parity/framing/break detection, FWFT receive FIFO.
module uart_rx_ovs #(
    parameter int unsigned CYCLES_PER_BIT = 8,
    parameter int unsigned PAYLOAD_BITS   = 8,
    parameter int unsigned PARITY_EN      = 0,
    parameter int unsigned PARITY_ODD     = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            uart_rxd,
    input  logic                            uart_rx_en,
    input  logic                            rd_ready,
    input  logic                            clr_err,
    output logic                            rd_valid,
    output logic [PAYLOAD_BITS-1:0]         rd_data,
    output logic                            rd_perr,
    output logic                            rd_ferr,
    output logic                            rx_break,
    output logic                            overrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic             ODD_PAR   = 1'(PARITY_ODD);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_e;

    typedef struct packed {
        logic                    ferr;
        logic                    perr;
        logic [PAYLOAD_BITS-1:0] data;
    } entry_t;

    logic                    sync1_q, sync2_q;
    logic [2:0]              hist_q;
    logic                    voted_c;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    perr_q, perr_d;
    logic                    par_q, par_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;
    logic                    frame_done_c;
    logic                    rx_break_q;

    entry_t                  mem_q [FIFO_DEPTH];
    entry_t                  frame_c;
    entry_t                  head_c;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    overrun_q, overrun_d;
    logic                    full_c, push_c, pop_c, wr_c;

    // Synchronizer and vote history; disabled receiver parks them at the idle level
    always_ff @(posedge clk) begin
        if (!rst_n || !uart_rx_en) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    assign voted_c = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            rx_break_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            rx_break_q <= frame_done_c & brk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        perr_d       = perr_q;
        par_d        = par_q;
        ferr_d       = ferr_q;
        brk_d        = brk_q;
        frame_done_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                perr_d    = 1'b0;
                par_d     = 1'b0;
                ferr_d    = 1'b0;
                brk_d     = 1'b0;
                if (!sync2_q) state_d = S_START;
            end
            // Half-bit check rejects glitches and re-aligns sampling to mid-bit
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = voted_c ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d  = '0;
                    data_d = {voted_c, data_q[PAYLOAD_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    par_d   = voted_c;
                    perr_d  = (^data_q) ^ voted_c ^ ODD_PAR;
                    state_d = S_STOP;
                end
            end
            // Break is judged on the first stop sample; the frame completes on the last
            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~voted_c;
                    if (bit_cnt_q == '0) begin
                        brk_d = (data_q == '0) && !par_q && !voted_c;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        frame_done_c = 1'b1;
                        bit_cnt_d    = '0;
                        state_d      = ferr_d ? S_WAIT_HI : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_WAIT_HI: begin
                cnt_d = '0;
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!uart_rx_en) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            frame_done_c = 1'b0;
        end
    end

    assign frame_c = '{ferr: ferr_d, perr: perr_q, data: data_q};

    // FIFO control: a push into a full FIFO only lands when a pop frees the slot
    assign full_c = (level_q == FULL_LVL);
    assign pop_c  = rd_valid & rd_ready;
    assign push_c = frame_done_c;
    assign wr_c   = push_c & (~full_c | pop_c);

    always_comb begin
        level_d = level_q;
        unique case ({wr_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        overrun_d = overrun_q;
        if (clr_err) overrun_d = 1'b0;
        if (push_c && full_c && !pop_c) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_c) begin
                mem_q[wr_ptr_q] <= frame_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign head_c     = mem_q[rd_ptr_q];
    assign rd_valid   = (level_q != '0);
    assign rd_data    = head_c.data;
    assign rd_perr    = head_c.perr;
    assign rd_ferr    = head_c.ferr;
    assign rx_break   = rx_break_q;
    assign overrun    = overrun_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench: an 8N1 receiver (a) and an 8E2 receiver (b) on a shared clock.
module tb_uart_rx_ovs;

    localparam int CPB      = 8;
    localparam int DONE_OFS = 2 + CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       rxd_a = 1'b1, en_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic       valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic [7:0] data_a;
    logic [2:0] lvl_a;

    logic       rxd_b = 1'b1, en_b = 1'b1, rdy_b = 1'b0, clr_b = 1'b0;
    logic       valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [7:0] data_b;
    logic [2:0] lvl_b;

    int total = 0;
    int bad   = 0;

    int   brk_cnt_a = 0;
    int   brk_cnt_b = 0;
    logic brk_misaligned = 1'b0;
    logic valid_prev_a = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ovs #(
        .CYCLES_PER_BIT(CPB), .PAYLOAD_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_a), .uart_rx_en(en_a),
        .rd_ready(rdy_a), .clr_err(clr_a), .rd_valid(valid_a), .rd_data(data_a),
        .rd_perr(perr_a), .rd_ferr(ferr_a), .rx_break(brk_a), .overrun(ovr_a),
        .fifo_level(lvl_a)
    );

    uart_rx_ovs #(
        .CYCLES_PER_BIT(CPB), .PAYLOAD_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_b), .uart_rx_en(en_b),
        .rd_ready(rdy_b), .clr_err(clr_b), .rd_valid(valid_b), .rd_data(data_b),
        .rd_perr(perr_b), .rd_ferr(ferr_b), .rx_break(brk_b), .overrun(ovr_b),
        .fifo_level(lvl_b)
    );

    // Break pulses must coincide with the rising edge of rd_valid
    always @(posedge clk) begin
        valid_prev_a <= valid_a;
        if (brk_a) begin
            brk_cnt_a <= brk_cnt_a + 1;
            if (!(valid_a && !valid_prev_a)) brk_misaligned <= 1'b1;
        end
        if (brk_b) brk_cnt_b <= brk_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int line, input logic b);
        if (line == 0) rxd_a = b;
        else           rxd_b = b;
    endtask

    // Sends bits[0..nbits-1] LSB first, one bit time each; optionally pops dut a
    // exactly on the clock edge that writes the frame.
    task automatic send_bits(input int line, input logic [15:0] bits, input int nbits,
                             input bit pop_at_done);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            drive(line, bits[i]);
            if (pop_at_done && i == nbits - 1) begin
                repeat (DONE_OFS) @(posedge clk);
                @(negedge clk);
                rdy_a = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rdy_a = 1'b0;
                repeat (CPB - DONE_OFS - 1) @(posedge clk);
            end else begin
                repeat (CPB) @(posedge clk);
            end
        end
    endtask

    task automatic idle(input int line, input int nbit_times);
        @(negedge clk);
        drive(line, 1'b1);
        repeat (nbit_times * CPB) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] fa(input logic [7:0] d);
        return {6'h3F, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] fb(input logic [7:0] d, input logic par, input logic s2);
        return {4'hF, s2, 1'b1, par, d, 1'b0};
    endfunction

    task automatic send_a(input logic [7:0] d);
        send_bits(0, fa(d), 10, 1'b0);
        idle(0, 2);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic s2);
        send_bits(1, fb(d, par, s2), 12, 1'b0);
        idle(1, 2);
    endtask

    task automatic pop_a;
        @(negedge clk);
        rdy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_a = 1'b0;
    endtask

    task automatic pop_b;
        @(negedge clk);
        rdy_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_b = 1'b0;
    endtask

    task automatic expect_head_a(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, 32'(valid_a), 32'd1);
        check({tag, "_data"},  32'(data_a),  32'(d));
    endtask

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_data_a",  32'(data_a),  32'd0);
        check("rst_flags_a", 32'({perr_a, ferr_a, brk_a, ovr_a}), 32'd0);
        check("rst_level_a", 32'(lvl_a),   32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        check("rst_flags_b", 32'({perr_b, ferr_b, brk_b, ovr_b}), 32'd0);
        check("rst_level_b", 32'(lvl_b),   32'd0);

        // 8N1 basic frame
        send_a(8'hA5);
        check("a5_level", 32'(lvl_a), 32'd1);
        expect_head_a("a5", 8'hA5);
        check("a5_perr", 32'(perr_a), 32'd0);
        check("a5_ferr", 32'(ferr_a), 32'd0);
        pop_a();
        check("a5_pop_level", 32'(lvl_a), 32'd0);
        check("a5_pop_valid", 32'(valid_a), 32'd0);

        // Short low glitch is rejected, then a real frame still lands
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rxd_a = 1'b1;
        idle(0, 2);
        check("glitch_level", 32'(lvl_a), 32'd0);
        send_a(8'h3A);
        check("post_glitch_level", 32'(lvl_a), 32'd1);
        expect_head_a("post_glitch", 8'h3A);

        // Receiver disabled during data bit 3 (0xC3 -> bit3 = 0)
        send_bits(0, fa(8'hC3), 4, 1'b0);
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en_a  = 1'b0;
        rxd_a = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        en_a = 1'b1;
        idle(0, 12);
        check("abort_level", 32'(lvl_a), 32'd1);
        expect_head_a("abort_keep", 8'h3A);
        pop_a();

        // Line held low for 20 bit times: one break entry, one pulse
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        idle(0, 3);
        check("brk_level", 32'(lvl_a), 32'd1);
        expect_head_a("brk", 8'h00);
        check("brk_ferr", 32'(ferr_a), 32'd1);
        check("brk_perr", 32'(perr_a), 32'd0);
        check("brk_pulses", 32'(brk_cnt_a), 32'd1);
        check("brk_aligned", 32'(brk_misaligned), 32'd0);
        pop_a();
        send_a(8'h7E);
        expect_head_a("after_brk", 8'h7E);
        check("after_brk_ferr", 32'(ferr_a), 32'd0);
        check("after_brk_pulses", 32'(brk_cnt_a), 32'd1);
        pop_a();

        // Overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_a(8'(i));
        check("ovr_level", 32'(lvl_a), 32'd4);
        check("ovr_flag", 32'(ovr_a), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            expect_head_a($sformatf("ovr_rd%0d", i), 8'(i));
            pop_a();
        end
        check("ovr_drained", 32'(lvl_a), 32'd0);
        check("ovr_sticky", 32'(ovr_a), 32'd1);
        @(negedge clk);
        clr_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_a = 1'b0;
        check("ovr_cleared", 32'(ovr_a), 32'd0);

        // Pop coincides with a push into a full FIFO
        for (int i = 1; i <= 4; i++) send_a(8'(8'h10 + i));
        check("full_level", 32'(lvl_a), 32'd4);
        send_bits(0, fa(8'h15), 10, 1'b1);
        idle(0, 2);
        check("pushpop_ovr", 32'(ovr_a), 32'd0);
        check("pushpop_level", 32'(lvl_a), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            expect_head_a($sformatf("pushpop_rd%0d", i), 8'(8'h10 + i));
            pop_a();
        end
        check("pushpop_drained", 32'(lvl_a), 32'd0);

        // 8E2: 0x3C has four ones, so parity bit 1 is an error and 0 is clean
        send_b(8'h3C, 1'b1, 1'b1);
        check("par1_level", 32'(lvl_b), 32'd1);
        check("par1_data", 32'(data_b), 32'h3C);
        check("par1_perr", 32'(perr_b), 32'd1);
        check("par1_ferr", 32'(ferr_b), 32'd0);
        pop_b();
        send_b(8'h3C, 1'b0, 1'b1);
        check("par0_data", 32'(data_b), 32'h3C);
        check("par0_perr", 32'(perr_b), 32'd0);
        pop_b();

        // Second stop bit low: framing error without a break
        send_b(8'h55, 1'b0, 1'b0);
        check("ferr_data", 32'(data_b), 32'h55);
        check("ferr_ferr", 32'(ferr_b), 32'd1);
        check("ferr_perr", 32'(perr_b), 32'd0);
        check("ferr_nobrk", 32'(brk_cnt_b), 32'd0);
        pop_b();
        send_b(8'h12, 1'b0, 1'b1);
        check("clean_level", 32'(lvl_b), 32'd1);
        check("clean_data", 32'(data_b), 32'h12);
        check("clean_flags", 32'({perr_b, ferr_b}), 32'd0);
        pop_b();
        check("b_drained", 32'(lvl_b), 32'd0);
        check("b_ovr", 32'(ovr_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
